fft_bitrev_reorder: RTL

Output reorder stage placed directly downstream of the Alter_FFT core. It accepts one FFT frame per burst in bit-reversed index order and re-emits it in natural frequency order (bin 0 first) through a ping-pong pair of sample buffers. Frame size is runtime-selectable from 16 to 128 points via the same `sel` encoding the FFT core uses. Because of the ping-pong buffering, the next frame can be captured while the previous one is read out.

---
 rtl/fft_bitrev_reorder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - bit-reversed to natural order FFT output reorder via ping-pong banks
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   sel[1:0]        frame size select: 00->16, 11->32, 01->64, 10->128 (latched at frame start)
//   di_en           input sample valid (bit-reversed order)
//   di_re/di_im     input sample components
//   do_en           output sample valid (natural order)
//   do_re/do_im     output sample components, held while do_en is low
//   ovf             one-cycle pulse when an input frame is dropped
//   do_sof/do_eof   first/last bin markers, present only with FFT_REORDER_FRAME_MARK_EN
//
// Optional feature macro: FFT_REORDER_FRAME_MARK_EN

module fft_bitrev_reorder #(
    parameter int WIDTH = 16,
    parameter int MAX_N = 128
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             ovf
`ifdef FFT_REORDER_FRAME_MARK_EN
    ,
    output logic             do_sof,
    output logic             do_eof
`endif
);

    localparam int ADDR_W = $clog2(MAX_N);

    localparam logic [1:0] BANK_EMPTY   = 2'd0;
    localparam logic [1:0] BANK_FILLING = 2'd1;
    localparam logic [1:0] BANK_FULL    = 2'd2;
    localparam logic [1:0] BANK_READING = 2'd3;

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_READ = 1'b1;

    // Reverse the low nlog bits of v: reverse the full word, then shift the
    // meaningful bits back down to the bottom.
    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v, input logic [2:0] nlog);
        logic [ADDR_W-1:0] r;
        for (int j = 0; j < ADDR_W; j++) begin
            r[j] = v[ADDR_W-1-j];
        end
        return r >> (ADDR_W - 32'(nlog));
    endfunction

    function automatic logic [ADDR_W-1:0] last_idx(input logic [2:0] nlog);
        return ADDR_W'((32'd1 << nlog) - 32'd1);
    endfunction

    logic [2*WIDTH-1:0] mem [2*MAX_N];

    logic [1:0]        bank_state [2];
    logic [2:0]        bank_nlog  [2];

    logic              wr_busy;
    logic              wr_drop;
    logic              wr_ptr;
    logic [ADDR_W-1:0] wr_cnt;
    logic [2:0]        wr_nlog;

    logic [0:0]        rd_state;
    logic              rd_ptr;
    logic [ADDR_W-1:0] rd_cnt;
    logic [2:0]        rd_nlog;

    logic [2*WIDTH-1:0] stage_data;
    logic               stage_valid;

    logic [2:0]        sel_nlog;
    logic              wr_start;
    logic              tgt_busy;
    logic [2:0]        cur_nlog;
    logic [ADDR_W-1:0] cur_cnt;
    logic              cur_drop;
    logic              wr_last;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic              rd_begin;
    logic              rd_issue;
    logic              rd_last;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W:0]   rd_addr;

    always_comb begin
        case (sel)
            2'b00:   sel_nlog = 3'd4;
            2'b11:   sel_nlog = 3'd5;
            2'b01:   sel_nlog = 3'd6;
            default: sel_nlog = 3'd7;
        endcase
    end

    // On the start cycle the frame parameters come straight from the inputs;
    // afterwards from the values latched at start.
    always_comb begin
        wr_start = di_en && !wr_busy;
        tgt_busy = (bank_state[wr_ptr] == BANK_FULL) || (bank_state[wr_ptr] == BANK_READING);
        cur_nlog = wr_start ? sel_nlog : wr_nlog;
        cur_cnt  = wr_start ? '0 : wr_cnt;
        cur_drop = wr_start ? tgt_busy : wr_drop;
        wr_last  = di_en && (cur_cnt == last_idx(cur_nlog));
        wr_en    = di_en && !cur_drop;
        wr_addr  = {wr_ptr, bitrev(cur_cnt, cur_nlog)};
    end

    // Address 0 is issued on the same edge the FSM leaves IDLE, so a bank is
    // released in time for a back-to-back frame of the same size.
    always_comb begin
        rd_begin = (rd_state == RD_IDLE) && (bank_state[rd_ptr] == BANK_FULL);
        rd_issue = rd_begin || (rd_state == RD_READ);
        rd_last  = (rd_state == RD_READ) && (rd_cnt == last_idx(rd_nlog));
        rd_idx   = rd_begin ? '0 : rd_cnt;
        rd_addr  = {rd_ptr, rd_idx};
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= {di_re, di_im};
        end
        if (rd_issue) begin
            stage_data <= mem[rd_addr];
        end
    end

    // Write side only touches EMPTY/FILLING banks and read side only FULL/READING
    // banks, so their bank_state updates never collide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
            bank_nlog[0]  <= '0;
            bank_nlog[1]  <= '0;
            wr_busy       <= 1'b0;
            wr_drop       <= 1'b0;
            wr_ptr        <= 1'b0;
            wr_cnt        <= '0;
            wr_nlog       <= '0;
            rd_state      <= RD_IDLE;
            rd_ptr        <= 1'b0;
            rd_cnt        <= '0;
            rd_nlog       <= '0;
            stage_valid   <= 1'b0;
            ovf           <= 1'b0;
            do_en         <= 1'b0;
            do_re         <= '0;
            do_im         <= '0;
        end else begin
            ovf <= wr_start && tgt_busy;

            if (di_en) begin
                if (wr_last) begin
                    wr_busy <= 1'b0;
                    wr_cnt  <= '0;
                end else begin
                    wr_busy <= 1'b1;
                    wr_cnt  <= cur_cnt + 1'b1;
                end
                if (wr_start) begin
                    wr_nlog <= sel_nlog;
                    wr_drop <= tgt_busy;
                end
                if (!cur_drop) begin
                    if (wr_start) begin
                        bank_nlog[wr_ptr]  <= sel_nlog;
                        bank_state[wr_ptr] <= BANK_FILLING;
                    end
                    if (wr_last) begin
                        bank_state[wr_ptr] <= BANK_FULL;
                        wr_ptr             <= ~wr_ptr;
                    end
                end
            end

            // Banks fill strictly alternately, so alternating rd_ptr always
            // lands on the oldest FULL bank.
            if (rd_begin) begin
                rd_state           <= RD_READ;
                rd_cnt             <= {{(ADDR_W-1){1'b0}}, 1'b1};
                rd_nlog            <= bank_nlog[rd_ptr];
                bank_state[rd_ptr] <= BANK_READING;
            end else if (rd_state == RD_READ) begin
                if (rd_last) begin
                    bank_state[rd_ptr] <= BANK_EMPTY;
                    rd_state           <= RD_IDLE;
                    rd_ptr             <= ~rd_ptr;
                    rd_cnt             <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end

            stage_valid <= rd_issue;
            do_en       <= stage_valid;
            if (stage_valid) begin
                do_re <= stage_data[2*WIDTH-1:WIDTH];
                do_im <= stage_data[WIDTH-1:0];
            end
        end
    end

`ifdef FFT_REORDER_FRAME_MARK_EN
    logic stage_sof;
    logic stage_eof;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_sof <= 1'b0;
            stage_eof <= 1'b0;
            do_sof    <= 1'b0;
            do_eof    <= 1'b0;
        end else begin
            stage_sof <= rd_begin;
            stage_eof <= rd_last;
            do_sof    <= stage_sof;
            do_eof    <= stage_eof;
        end
    end
`endif

endmodule
